// File: rtl/mips_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_arith_pkg
//  Purpose  : Shared definitions for the MIPS integer datapath block and the
//             control unit that drives it: default datapath width, ALU
//             operation codes and branch-condition codes.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mips_arith_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef logic [4:0] alu_ctrl_t;
  typedef logic [3:0] bcu_ctrl_t;

  // ALU operation codes; 15..31 are reserved and produce a zero result.
  localparam alu_ctrl_t ALU_ADD   = 5'd0;
  localparam alu_ctrl_t ALU_ADDU  = 5'd1;
  localparam alu_ctrl_t ALU_SUB   = 5'd2;
  localparam alu_ctrl_t ALU_SUBU  = 5'd3;
  localparam alu_ctrl_t ALU_AND   = 5'd4;
  localparam alu_ctrl_t ALU_OR    = 5'd5;
  localparam alu_ctrl_t ALU_XOR   = 5'd6;
  localparam alu_ctrl_t ALU_NOR   = 5'd7;
  localparam alu_ctrl_t ALU_SLT   = 5'd8;
  localparam alu_ctrl_t ALU_SLTU  = 5'd9;
  localparam alu_ctrl_t ALU_SLL   = 5'd10;
  localparam alu_ctrl_t ALU_SRL   = 5'd11;
  localparam alu_ctrl_t ALU_SRA   = 5'd12;
  localparam alu_ctrl_t ALU_PASSB = 5'd13;
  localparam alu_ctrl_t ALU_PASSA = 5'd14;

  // Branch condition codes; 6..15 never branch.
  localparam bcu_ctrl_t BCU_BEQ  = 4'd0;
  localparam bcu_ctrl_t BCU_BNE  = 4'd1;
  localparam bcu_ctrl_t BCU_BLEZ = 4'd2;
  localparam bcu_ctrl_t BCU_BGTZ = 4'd3;
  localparam bcu_ctrl_t BCU_BLTZ = 4'd4;
  localparam bcu_ctrl_t BCU_BGEZ = 4'd5;

endpackage
`default_nettype wire

// File: rtl/mips_bcu_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : mips_bcu_cmp
//  Purpose  : Decode-stage branch comparison unit. Pure combinational
//             evaluation of the branch condition on signed operands.
//  Ports    : ctrl   - branch condition code
//             rd1    - compare operand 1 (rs)
//             rd2    - compare operand 2 (rt), used by BEQ/BNE only
//             branch - condition true (not gated by BranchD here)
//  Revision : 1.0 - initial release
// ============================================================================
module mips_bcu_cmp
  import mips_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic             branch
);

  logic w_eq;
  logic w_neg;
  logic w_zero;

  // Sign-against-zero tests need only the MSB and a zero detect.
  assign w_eq   = (rd1 == rd2);
  assign w_neg  = rd1[WIDTH-1];
  assign w_zero = (rd1 == '0);

  always_comb begin
    branch = 1'b0;
    case (ctrl)
      BCU_BEQ:  branch = w_eq;
      BCU_BNE:  branch = ~w_eq;
      BCU_BLEZ: branch = w_neg | w_zero;
      BCU_BGTZ: branch = ~w_neg & ~w_zero;
      BCU_BLTZ: branch = w_neg;
      BCU_BGEZ: branch = ~w_neg;
      default:  branch = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_arith_core.sv
`default_nettype none
// ============================================================================
//  Module   : mips_arith_core
//  Purpose  : Integer datapath block of the 5-stage MIPS pipeline: general
//             adder (PC+4 / branch target), execute-stage ALU and
//             decode-stage branch comparison unit. All primary results are
//             combinational; registered copies and a sticky overflow flag
//             are kept for debug/trace.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             add_a, add_b, add_sum - general adder
//             alu_a, alu_b, alu_ctrl, alu_result, alu_ovf - ALU
//             bcu_ctrl, bcu_rd1, bcu_rd2, branch          - branch compare
//             alu_result_q, branch_q, ovf_sticky          - trace registers
//  Revision : 1.0 - initial release
// ============================================================================
module mips_arith_core
  import mips_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] add_a,
  input  logic [WIDTH-1:0] add_b,
  output logic [WIDTH-1:0] add_sum,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       alu_ctrl,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_ovf,
  input  logic [3:0]       bcu_ctrl,
  input  logic [WIDTH-1:0] bcu_rd1,
  input  logic [WIDTH-1:0] bcu_rd2,
  output logic             branch,
  output logic [WIDTH-1:0] alu_result_q,
  output logic             branch_q,
  output logic             ovf_sticky
);

  // --------------------------------------------------------------------------
  // General adder
  // --------------------------------------------------------------------------
  assign add_sum = add_a + add_b;

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_add_ovf;
  logic             w_sub_ovf;
  logic [4:0]       w_shamt;

  assign w_sum  = alu_a + alu_b;
  assign w_diff = alu_a - alu_b;

  // Signed overflow: ADD when operand signs agree, SUB when they differ,
  // and in both cases the result sign departs from operand A.
  assign w_add_ovf = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                     (w_sum[WIDTH-1]  != alu_a[WIDTH-1]);
  assign w_sub_ovf = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                     (w_diff[WIDTH-1] != alu_a[WIDTH-1]);

  // Shift amount comes from A (the shamt/rs field); upper bits ignored.
  assign w_shamt = alu_a[4:0];

  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (alu_ctrl)
      ALU_ADD: begin
        alu_result = w_sum;
        alu_ovf    = w_add_ovf;
      end
      ALU_ADDU: alu_result = w_sum;
      ALU_SUB: begin
        alu_result = w_diff;
        alu_ovf    = w_sub_ovf;
      end
      ALU_SUBU:  alu_result = w_diff;
      ALU_AND:   alu_result = alu_a & alu_b;
      ALU_OR:    alu_result = alu_a | alu_b;
      ALU_XOR:   alu_result = alu_a ^ alu_b;
      ALU_NOR:   alu_result = ~(alu_a | alu_b);
      ALU_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      ALU_SLL:   alu_result = alu_b << w_shamt;
      ALU_SRL:   alu_result = alu_b >> w_shamt;
      ALU_SRA:   alu_result = $unsigned($signed(alu_b) >>> w_shamt);
      // lui's 16-bit shift happens in writeback, so B passes through as-is.
      ALU_PASSB: alu_result = alu_b;
      ALU_PASSA: alu_result = alu_a;
      default: begin
        alu_result = '0;
        alu_ovf    = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Branch comparison unit
  // --------------------------------------------------------------------------
  mips_bcu_cmp #(
    .WIDTH (WIDTH)
  ) u_bcu (
    .ctrl   (bcu_ctrl),
    .rd1    (bcu_rd1),
    .rd2    (bcu_rd2),
    .branch (branch)
  );

  // --------------------------------------------------------------------------
  // Trace registers. Reset has priority over a coincident overflow.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_q <= '0;
      branch_q     <= 1'b0;
      ovf_sticky   <= 1'b0;
    end else begin
      alu_result_q <= alu_result;
      branch_q     <= branch;
      ovf_sticky   <= ovf_sticky | alu_ovf;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_arith_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_arith_core
//  Purpose  : Directed self-checking bench for mips_arith_core.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mips_arith_core;

  logic        clk;
  logic        reset;
  logic [31:0] add_a, add_b, add_sum;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_ctrl;
  logic        alu_ovf;
  logic [3:0]  bcu_ctrl;
  logic [31:0] bcu_rd1, bcu_rd2;
  logic        branch;
  logic [31:0] alu_result_q;
  logic        branch_q;
  logic        ovf_sticky;

  int errors = 0;
  int checks = 0;

  mips_arith_core #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_sum      (add_sum),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctrl     (alu_ctrl),
    .alu_result   (alu_result),
    .alu_ovf      (alu_ovf),
    .bcu_ctrl     (bcu_ctrl),
    .bcu_rd1      (bcu_rd1),
    .bcu_rd2      (bcu_rd2),
    .branch       (branch),
    .alu_result_q (alu_result_q),
    .branch_q     (branch_q),
    .ovf_sticky   (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        ovf;
  } alu_vec_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        exp;
  } bcu_vec_t;

  localparam alu_vec_t ALU_VEC [0:16] = '{
    '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1}, // ADD ovf
    '{5'd1,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0}, // ADDU
    '{5'd2,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b0}, // SUB
    '{5'd2,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1}, // SUB ovf
    '{5'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0}, // SUBU
    '{5'd0,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1}, // ADD neg ovf
    '{5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0}, // SLT
    '{5'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0}, // SLTU
    '{5'd12, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0}, // SRA
    '{5'd11, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0}, // SRL
    '{5'd10, 32'h00000023, 32'h00000001, 32'h00000008, 1'b0}, // SLL a[4:0]=3
    '{5'd7,  32'h00000000, 32'h0000FFFF, 32'hFFFF0000, 1'b0}, // NOR
    '{5'd4,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0}, // AND
    '{5'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0}, // OR
    '{5'd6,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0}, // XOR
    '{5'd13, 32'hDEADBEEF, 32'h00001234, 32'h00001234, 1'b0}, // PASSB
    '{5'd14, 32'hDEADBEEF, 32'h00001234, 32'hDEADBEEF, 1'b0}  // PASSA
  };

  localparam bcu_vec_t BCU_VEC [0:14] = '{
    '{4'd0, 32'h00000007, 32'h00000007, 1'b1}, // BEQ equal
    '{4'd1, 32'h00000007, 32'h00000007, 1'b0}, // BNE equal
    '{4'd0, 32'h00000007, 32'h00000008, 1'b0}, // BEQ differ
    '{4'd1, 32'h00000007, 32'h00000008, 1'b1}, // BNE differ
    '{4'd2, 32'h00000000, 32'h00000005, 1'b1}, // BLEZ 0, rd2 ignored
    '{4'd2, 32'h00000001, 32'h00000000, 1'b0}, // BLEZ 1
    '{4'd3, 32'h80000000, 32'h00000000, 1'b0}, // BGTZ most negative
    '{4'd3, 32'h00000001, 32'h00000000, 1'b1}, // BGTZ 1
    '{4'd3, 32'h00000000, 32'h00000000, 1'b0}, // BGTZ 0
    '{4'd4, 32'hFFFFFFFF, 32'h00000000, 1'b1}, // BLTZ -1
    '{4'd4, 32'h00000000, 32'h00000000, 1'b0}, // BLTZ 0
    '{4'd5, 32'h00000000, 32'h00000000, 1'b1}, // BGEZ 0
    '{4'd5, 32'h80000000, 32'h00000000, 1'b0}, // BGEZ neg
    '{4'd9, 32'h00000007, 32'h00000007, 1'b0}, // reserved
    '{4'd15, 32'h00000000, 32'h00000000, 1'b0} // reserved
  };

  task automatic test_reset();
    reset = 1'b1;
    add_a = '0; add_b = '0;
    alu_a = 32'h7FFFFFFF; alu_b = 32'h1; alu_ctrl = 5'd0;
    bcu_ctrl = 4'd0; bcu_rd1 = '0; bcu_rd2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_result_q !== 32'h0) begin
      errors++; $display("FAIL reset_result_q got=%h exp=%h", alu_result_q, 32'h0);
    end
    checks++;
    if (branch_q !== 1'b0) begin
      errors++; $display("FAIL reset_branch_q got=%b exp=0", branch_q);
    end
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("FAIL reset_ovf_sticky got=%b exp=0", ovf_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    alu_ctrl = 5'd1;
  endtask

  task automatic test_adder();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] ev [3];
    av = '{32'h00400000, 32'hFFFFFFFC, 32'hFFFFFFFF};
    bv = '{32'h00000004, 32'h00000008, 32'h00000001};
    ev = '{32'h00400004, 32'h00000004, 32'h00000000};
    for (int i = 0; i < 3; i++) begin
      add_a = av[i]; add_b = bv[i];
      #1;
      checks++;
      if (add_sum !== ev[i]) begin
        errors++; $display("FAIL adder[%0d] got=%h exp=%h", i, add_sum, ev[i]);
      end
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 17; i++) begin
      alu_ctrl = ALU_VEC[i].op; alu_a = ALU_VEC[i].a; alu_b = ALU_VEC[i].b;
      #1;
      checks++;
      if (alu_result !== ALU_VEC[i].exp) begin
        errors++;
        $display("FAIL alu[%0d] op=%0d result got=%h exp=%h", i, ALU_VEC[i].op, alu_result, ALU_VEC[i].exp);
      end
      checks++;
      if (alu_ovf !== ALU_VEC[i].ovf) begin
        errors++;
        $display("FAIL alu[%0d] op=%0d ovf got=%b exp=%b", i, ALU_VEC[i].op, alu_ovf, ALU_VEC[i].ovf);
      end
    end
  endtask

  task automatic test_alu_reserved();
    logic [4:0] codes [3];
    codes = '{5'd15, 5'd20, 5'd31};
    alu_a = 32'h7FFFFFFF; alu_b = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      alu_ctrl = codes[i];
      #1;
      checks++;
      if (alu_result !== 32'h0 || alu_ovf !== 1'b0) begin
        errors++;
        $display("FAIL alu_reserved code=%0d got=%h/%b exp=00000000/0", codes[i], alu_result, alu_ovf);
      end
    end
  endtask

  task automatic test_bcu();
    for (int i = 0; i < 15; i++) begin
      bcu_ctrl = BCU_VEC[i].op; bcu_rd1 = BCU_VEC[i].rd1; bcu_rd2 = BCU_VEC[i].rd2;
      #1;
      checks++;
      if (branch !== BCU_VEC[i].exp) begin
        errors++;
        $display("FAIL bcu[%0d] code=%0d got=%b exp=%b", i, BCU_VEC[i].op, branch, BCU_VEC[i].exp);
      end
    end
  endtask

  task automatic test_sticky();
    // No overflow first: sticky must stay clear.
    @(negedge clk);
    alu_ctrl = 5'd1; alu_a = 32'h7FFFFFFF; alu_b = 32'h1;
    @(posedge clk); #1;
    checks++;
    if (ovf_sticky !== 1'b0) begin
      errors++; $display("FAIL sticky_addu got=%b exp=0", ovf_sticky);
    end
    checks++;
    if (alu_result_q !== 32'h80000000) begin
      errors++; $display("FAIL result_q_addu got=%h exp=80000000", alu_result_q);
    end
    @(negedge clk);
    alu_ctrl = 5'd0;
    @(posedge clk); #1;
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++; $display("FAIL sticky_add_ovf got=%b exp=1", ovf_sticky);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1;
    alu_ctrl = 5'd0; alu_a = 32'h7FFFFFFF; alu_b = 32'h1;
    bcu_ctrl = 4'd0; bcu_rd1 = 32'h7; bcu_rd2 = 32'h7;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (alu_result_q !== 32'h0 || branch_q !== 1'b0 || ovf_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_vs_ovf got q=%h br=%b st=%b exp q=00000000 br=0 st=0", alu_result_q, branch_q, ovf_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (alu_result_q !== 32'h80000000 || branch_q !== 1'b1 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got q=%h br=%b st=%b exp q=80000000 br=1 st=1", alu_result_q, branch_q, ovf_sticky);
    end
    // Overflow goes away; sticky must hold while trace registers follow.
    @(negedge clk);
    alu_a = 32'h1; alu_b = 32'h2;
    bcu_ctrl = 4'd1;
    @(posedge clk); #1;
    checks++;
    if (alu_result_q !== 32'h3 || branch_q !== 1'b0 || ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_hold got q=%h br=%b st=%b exp q=00000003 br=0 st=1", alu_result_q, branch_q, ovf_sticky);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ev [3];
    ev = '{32'h00000010, 32'h00000020, 32'h00000030};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_ctrl = 5'd1; alu_a = 32'h10 * (i + 1); alu_b = 32'h0;
      @(posedge clk); #1;
      checks++;
      if (alu_result_q !== ev[i]) begin
        errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, alu_result_q, ev[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_adder();
    test_alu();
    test_alu_reserved();
    test_bcu();
    test_sticky();
    test_reset_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_arith_core.md
Name: mips_arith_core

Overview:
Combined integer datapath block for the 5-stage pipelined MIPS CPU. It contains three units:
- a general 32-bit adder, used for PC+4 and the branch target;
- the execute-stage ALU, driven by a 5-bit control code;
- the decode-stage branch comparison unit (BCU), driven by a 4-bit control code.

All three results are combinational, as the pipeline requires. Registered copies and a sticky overflow flag are also provided for debug and trace.

Parameters:
WIDTH, 32, datapath width for adder, ALU and BCU operands.

Ports:
clk  in  1  single clock, rising-edge.
reset  in  1  synchronous, active-high; clears registered outputs only.
add_a  in  WIDTH  adder operand A.
add_b  in  WIDTH  adder operand B.
add_sum  out  WIDTH  add_a+add_b mod 2^WIDTH, combinational.
alu_a  in  WIDTH  ALU source A (rs / forwarded).
alu_b  in  WIDTH  ALU source B (rt / immediate).
alu_ctrl  in  5  ALU operation code.
alu_result  out  WIDTH  combinational ALU result.
alu_ovf  out  1  signed overflow of ADD/SUB, combinational; 0 for other ops.
bcu_ctrl  in  4  branch condition code.
bcu_rd1  in  WIDTH  compare operand 1 (rs).
bcu_rd2  in  WIDTH  compare operand 2 (rt).
branch  out  1  condition true, combinational.
alu_result_q  out  WIDTH  alu_result registered.
branch_q  out  1  branch registered.
ovf_sticky  out  1  set when alu_ovf=1 at a clock edge; cleared only by reset.

Behaviour:
Combinational paths:
- add_sum, alu_result, alu_ovf and branch have zero latency and are pure functions of the inputs. No clock involvement.

ALU codes (alu_ctrl):
- 0 ADD: a+b, wraps.
- 1 ADDU: a+b; alu_ovf=0.
- 2 SUB: a-b, wraps.
- 3 SUBU: a-b; alu_ovf=0.
- 4 AND, 5 OR, 6 XOR, 7 NOR: bitwise.
- 8 SLT: signed a<b gives 1, else 0, zero-extended.
- 9 SLTU: unsigned a<b gives 1, else 0.
- 10 SLL: b<<a[4:0].
- 11 SRL: b>>a[4:0], logical.
- 12 SRA: b>>>a[4:0], arithmetic.
- 13 PASSB: b. Used by lui; the 16-bit shift is done in writeback.
- 14 PASSA: a.
- 15..31: result 0, alu_ovf 0.

Overflow rule:
- Signed overflow = operand signs match (ADD), or differ (SUB), and the result sign differs from a.
- Only bits [4:0] of a are used as the shift amount.

BCU codes (bcu_ctrl), operands signed:
- 0 BEQ: rd1==rd2.
- 1 BNE: rd1!=rd2.
- 2 BLEZ: rd1<=0.
- 3 BGTZ: rd1>0.
- 4 BLTZ: rd1<0.
- 5 BGEZ: rd1>=0.
- 6..15: branch=0.
- rd2 is ignored for codes 2..5.
- The caller gates branch with its own BranchD signal; the BCU does not.

Registered outputs:
- At each rising edge: if reset, alu_result_q=0, branch_q=0, ovf_sticky=0.
- Otherwise alu_result_q<=alu_result, branch_q<=branch, ovf_sticky<=ovf_sticky|alu_ovf.
- Reset asserted in the same cycle as an overflow: reset wins, ovf_sticky=0.
- Outputs are X-free after the first reset edge.
- X/Z inputs propagate X; no requirement.

Decomposition:
- Shared package mips_arith_pkg holds:
  - ALU code localparams (ALU_ADD..ALU_PASSA);
  - BCU code localparams (BCU_BEQ..BCU_BGEZ);
  - WIDTH default.
- The control unit imports the same package.
- One natural sub-module: mips_bcu_cmp (pure comparator), instantiated once.
- The adder is an inline assign; the ALU is a case statement in the top.

Test Plan:
1. add_a=0x00400000, add_b=4 -> add_sum=0x00400004. add_a=0xFFFFFFFC, add_b=8 -> add_sum=0x00000004.
2. ALU ADD a=0x7FFFFFFF b=1 -> 0x80000000, alu_ovf=1, ovf_sticky=1 next edge. ADDU, same operands -> alu_ovf=0. SUB a=5 b=7 -> 0xFFFFFFFE, ovf=0.
3. SLT a=0xFFFFFFFF b=1 -> 1. SLTU, same operands -> 0. SRA b=0x80000000 a=4 -> 0xF8000000. SRL, same operands -> 0x08000000. SLL b=1 a=0x23 -> 0x00000008.
4. NOR a=0 b=0x0000FFFF -> 0xFFFF0000. PASSB b=0x1234 -> 0x00001234. Code 20 -> 0.
5. BCU: BEQ 7,7 -> 1. BNE 7,7 -> 0. BLEZ 0 -> 1. BGTZ 0x80000000 -> 0. BLTZ 0xFFFFFFFF -> 1. BGEZ 0 -> 1. Code 9 -> 0.
6. Hold reset 2 cycles during an overflowing ADD -> alu_result_q=0, branch_q=0, ovf_sticky=0. Release reset -> alu_result_q follows alu_result one cycle later; ovf_sticky stays 1 after overflow clears.
